// File: rtl/lif_array_if.sv
// lif_array bus bundle: step strobe, currents and threshold control in; membrane, spike and threshold out.
// With LIF_ADAPT_EN defined the per-neuron adaptation offsets are carried as well.
interface lif_array_if #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8
);
  logic                        en;
  logic [N_NEURONS*WIDTH-1:0]  current;
  logic [WIDTH-1:0]            thresh_in;
  logic                        thresh_load;
  logic                        reset_mode;
  logic [N_NEURONS*WIDTH-1:0]  state;
  logic [N_NEURONS-1:0]        spike;
  logic [WIDTH-1:0]            threshold;
`ifdef LIF_ADAPT_EN
  logic [N_NEURONS*WIDTH-1:0]  adapt_offset;
`endif

  modport master (
    output en, current, thresh_in, thresh_load, reset_mode,
`ifdef LIF_ADAPT_EN
    input  adapt_offset,
`endif
    input  state, spike, threshold
  );

  modport slave (
    input  en, current, thresh_in, thresh_load, reset_mode,
`ifdef LIF_ADAPT_EN
    output adapt_offset,
`endif
    output state, spike, threshold
  );
endinterface

// File: rtl/lif_array.sv
// N-neuron leaky integrate-and-fire array; spikes are registered, one cycle after the firing en step.
// No backpressure: every en cycle is a step. LIF_ADAPT_EN adds per-neuron adaptive threshold offsets.
module lif_array #(
  parameter int N_NEURONS      = 4,
  parameter int WIDTH          = 8,
  parameter int LEAK_SHIFT     = 1,
  parameter int REFRAC_CYCLES  = 2,
  parameter int THRESH_DEFAULT = 200
) (
  input  logic        clk,
  input  logic        reset,
  lif_array_if.slave  bus
);

  localparam int RW = (REFRAC_CYCLES < 1) ? 1 : $clog2(REFRAC_CYCLES + 1);
  localparam logic [RW-1:0]    REFRAC_LOAD = REFRAC_CYCLES[RW-1:0];
  localparam logic [RW-1:0]    REFRAC_ONE  = 1;
  localparam logic [WIDTH-1:0] TH_RESET    = THRESH_DEFAULT[WIDTH-1:0];

  logic [WIDTH-1:0]           thr_q;
  logic [N_NEURONS*WIDTH-1:0] state_vec;
  logic [N_NEURONS-1:0]       spike_vec;
`ifdef LIF_ADAPT_EN
  logic [N_NEURONS*WIDTH-1:0] offset_vec;
`endif

  // A load coinciding with a step still lets that step see the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      thr_q <= TH_RESET;
    end else if (bus.thresh_load) begin
      thr_q <= bus.thresh_in;
    end
  end

  for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron
    logic [WIDTH-1:0] mem_q, mem_d;
    logic [RW-1:0]    refrac_q, refrac_d;
    logic             spike_q, spike_d;
    logic [WIDTH:0]   sum_wide;
    logic [WIDTH-1:0] sum_sat;
    logic [WIDTH-1:0] eff_th;
    logic             active;
    logic             fire;
`ifdef LIF_ADAPT_EN
    logic [WIDTH-1:0] off_q, off_d;
    logic [WIDTH:0]   th_wide;
    logic [WIDTH:0]   off_wide;
`endif

    always_comb begin
      sum_wide = {1'b0, bus.current[i*WIDTH +: WIDTH]} + {1'b0, (mem_q >> LEAK_SHIFT)};
      sum_sat  = sum_wide[WIDTH] ? {WIDTH{1'b1}} : sum_wide[WIDTH-1:0];
`ifdef LIF_ADAPT_EN
      th_wide  = {1'b0, thr_q} + {1'b0, off_q};
      eff_th   = th_wide[WIDTH] ? {WIDTH{1'b1}} : th_wide[WIDTH-1:0];
`else
      eff_th   = thr_q;
`endif
      active   = bus.en && (refrac_q == '0);
      fire     = active && (sum_sat >= eff_th);
    end

    always_comb begin
      mem_d    = mem_q;
      refrac_d = refrac_q;
      spike_d  = 1'b0;
      if (bus.en) begin
        if (refrac_q != '0) begin
          refrac_d = refrac_q - REFRAC_ONE;
        end else if (fire) begin
          spike_d  = 1'b1;
          refrac_d = REFRAC_LOAD;
          mem_d    = bus.reset_mode ? (sum_sat - eff_th) : '0;
        end else begin
          mem_d    = sum_sat;
        end
      end
    end

`ifdef LIF_ADAPT_EN
    // Offset grows by a quarter threshold per spike and bleeds off one per quiet step.
    always_comb begin
      off_wide = {1'b0, off_q} + {1'b0, (thr_q >> 2)};
      off_d    = off_q;
      if (fire) begin
        off_d = off_wide[WIDTH] ? {WIDTH{1'b1}} : off_wide[WIDTH-1:0];
      end else if (active && (off_q != '0)) begin
        off_d = off_q - {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        off_q <= '0;
      end else begin
        off_q <= off_d;
      end
    end

    assign offset_vec[i*WIDTH +: WIDTH] = off_q;
`endif

    always_ff @(posedge clk) begin
      if (reset) begin
        mem_q    <= '0;
        refrac_q <= '0;
        spike_q  <= 1'b0;
      end else begin
        mem_q    <= mem_d;
        refrac_q <= refrac_d;
        spike_q  <= spike_d;
      end
    end

    assign state_vec[i*WIDTH +: WIDTH] = mem_q;
    assign spike_vec[i]                = spike_q;
  end

  assign bus.state     = state_vec;
  assign bus.spike     = spike_vec;
  assign bus.threshold = thr_q;
`ifdef LIF_ADAPT_EN
  assign bus.adapt_offset = offset_vec;
`endif

endmodule
